// File: rtl/vdp_io_pkg.sv
// Shared types and constants for the VDP I/O write queue.
package vdp_io_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned PORT_W        = 2;
    localparam int unsigned DATA_W        = 8;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } io_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_WR_ISSUE      = 2'd1,
        ST_RD_WAIT_DRAIN = 2'd2,
        ST_RD_ISSUE      = 2'd3
    } io_state_t;

endpackage

// File: rtl/vdp_io_queue_if.sv
// CPU-side and VDP-side signals of the I/O queue; the queue is the slave, its environment the master.
interface vdp_io_queue_if;
    import vdp_io_pkg::*;

    logic              cpu_req;
    logic              cpu_wr;
    logic [PORT_W-1:0] cpu_port;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rd_valid;
    logic              cpu_busy;
    logic              q_full;
    logic              vdp_io_req;
    logic              vdp_io_wr;
    logic [PORT_W-1:0] vdp_port;
    logic [DATA_W-1:0] vdp_data_out;
    logic [DATA_W-1:0] vdp_data_in;
    logic              vdp_ack;

    modport master (
        output cpu_req, cpu_wr, cpu_port, cpu_wdata, vdp_data_in, vdp_ack,
        input  cpu_rdata, cpu_rd_valid, cpu_busy, q_full,
               vdp_io_req, vdp_io_wr, vdp_port, vdp_data_out
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_port, cpu_wdata, vdp_data_in, vdp_ack,
        output cpu_rdata, cpu_rd_valid, cpu_busy, q_full,
               vdp_io_req, vdp_io_wr, vdp_port, vdp_data_out
    );

endinterface

// File: rtl/vdp_io_fifo.sv
// Synchronous FIFO of {port, data} write entries; a push on a full queue is taken when a pop coincides.
module vdp_io_fifo
    import vdp_io_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  io_entry_t              push_data_i,
    input  logic                   pop_i,
    output io_entry_t              head_c_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    io_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        pop_ok   = pop_i & ~empty_q;
        push_ok  = push_i & (~full_q | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/vdp_io_queue.sv
// CPU-to-VDP port access sequencer: queues writes, orders reads behind earlier writes.
// Optional drop statistics outputs enabled by defining VDP_IO_QUEUE_DROP_STATS_EN.
module vdp_io_queue
    import vdp_io_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    vdp_io_queue_if.slave  bus
`ifdef VDP_IO_QUEUE_DROP_STATS_EN
    ,
    output logic           drop_flag,
    output logic [7:0]     drop_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    io_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PORT_W-1:0] rd_port_q, rd_port_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;

    logic              wr_strobe, rd_strobe;
    logic              push, pop, wr_drop, rd_drop, rd_accept;
    io_entry_t         push_entry, head, issue_entry;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        wr_strobe   = bus.cpu_req & bus.cpu_wr;
        rd_strobe   = bus.cpu_req & ~bus.cpu_wr;
        pop         = (state_q == ST_WR_ISSUE) & bus.vdp_ack;
        push        = wr_strobe & (~fifo_full | pop);
        wr_drop     = wr_strobe & ~push;
        rd_accept   = rd_strobe & ~busy_q;
        rd_drop     = rd_strobe & busy_q;
        push_entry  = '{port: bus.cpu_port, data: bus.cpu_wdata};
        // A write into an empty queue is issued straight from the CPU bus.
        issue_entry = fifo_empty ? push_entry : head;
    end

    vdp_io_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_c_o    (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Next state and registered request/read-side outputs.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wr_d       = wr_q;
        port_d     = port_q;
        data_d     = data_q;
        busy_d     = busy_q;
        rd_valid_d = 1'b0;
        rdata_d    = rdata_q;
        rd_port_d  = rd_port_q;
        pre_cnt_d  = pre_cnt_q;

        // pre_cnt counts queued writes that were ahead of the pending read.
        if (rd_accept) begin
            busy_d    = 1'b1;
            rd_port_d = bus.cpu_port;
            pre_cnt_d = fifo_count - CNT_W'(pop);
        end else if (busy_q && pop && (pre_cnt_q != '0)) begin
            pre_cnt_d = pre_cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_accept) begin
                    state_d = ST_RD_WAIT_DRAIN;
                end else if (~fifo_empty | push) begin
                    state_d = ST_WR_ISSUE;
                    req_d   = 1'b1;
                    wr_d    = 1'b1;
                    port_d  = issue_entry.port;
                    data_d  = issue_entry.data;
                end
            end
            ST_WR_ISSUE: begin
                if (bus.vdp_ack) begin
                    req_d   = 1'b0;
                    state_d = (busy_q | rd_accept) ? ST_RD_WAIT_DRAIN : ST_IDLE;
                end
            end
            ST_RD_WAIT_DRAIN: begin
                state_d = ST_WR_ISSUE;
                req_d   = 1'b1;
                if (pre_cnt_q == '0) begin
                    state_d = ST_RD_ISSUE;
                    wr_d    = 1'b0;
                    port_d  = rd_port_q;
                end else begin
                    wr_d    = 1'b1;
                    port_d  = head.port;
                    data_d  = head.data;
                end
            end
            ST_RD_ISSUE: begin
                if (bus.vdp_ack) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    rdata_d    = bus.vdp_data_in;
                    rd_valid_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            port_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
            rd_port_q  <= '0;
            pre_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            port_q     <= port_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
            rd_port_q  <= rd_port_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end

    assign bus.vdp_io_req   = req_q;
    assign bus.vdp_io_wr    = wr_q;
    assign bus.vdp_port     = port_q;
    assign bus.vdp_data_out = data_q;
    assign bus.cpu_busy     = busy_q;
    assign bus.cpu_rd_valid = rd_valid_q;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.q_full       = fifo_full;

`ifdef VDP_IO_QUEUE_DROP_STATS_EN
    logic       drop_flag_q, drop_flag_d;
    logic [7:0] drop_count_q, drop_count_d;

    // Sticky flag and saturating count of dropped writes and ignored reads.
    always_comb begin
        drop_flag_d  = drop_flag_q;
        drop_count_d = drop_count_q;
        if (wr_drop | rd_drop) begin
            drop_flag_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_flag_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_flag  = drop_flag_q;
    assign drop_count = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = wr_drop | rd_drop;
`endif

endmodule

// File: tb/tb_vdp_io_queue.sv
// Self-checking bench for vdp_io_queue: vector table, directed corner sequences, random vs transaction model.
module tb_vdp_io_queue;
    import vdp_io_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdp_io_queue_if bus ();

`ifdef VDP_IO_QUEUE_DROP_STATS_EN
    logic       drop_flag;
    logic [7:0] drop_count;
`endif

    vdp_io_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef VDP_IO_QUEUE_DROP_STATS_EN
        ,
        .drop_flag  (drop_flag),
        .drop_count (drop_count)
`endif
    );

    typedef struct packed {
        logic       req;
        logic       wr;
        logic [1:0] port;
        logic [7:0] data;
        logic       busy;
        logic       rdv;
        logic [7:0] rdata;
        logic       full;
    } outs_t;

    typedef struct packed {
        logic       c_req;
        logic       c_wr;
        logic [1:0] c_port;
        logic [7:0] c_wdata;
        logic       ack;
        logic [7:0] din;
        outs_t      exp;
    } vec_t;

    typedef struct packed {
        logic       wr;
        logic [1:0] port;
        logic [7:0] data;
    } op_t;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference state
    op_t        exp_q[$];
    int         model_cnt;
    logic       model_busy;
    logic       exp_rdv;
    logic [7:0] pend_rdata;
    logic       prev_ack;
    int         drops_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [1:0] cp,
                         input logic [7:0] wd, input logic ak, input logic [7:0] di);
        bus.cpu_req     = cr;
        bus.cpu_wr      = cw;
        bus.cpu_port    = cp;
        bus.cpu_wdata   = wd;
        bus.vdp_ack     = ak;
        bus.vdp_data_in = di;
    endtask

    function automatic outs_t sample();
        return {bus.vdp_io_req, bus.vdp_io_wr, bus.vdp_port, bus.vdp_data_out,
                bus.cpu_busy, bus.cpu_rd_valid, bus.cpu_rdata, bus.q_full};
    endfunction

    function automatic vec_t mk(input logic cr, input logic cw, input logic [1:0] cp,
                                input logic [7:0] wd, input logic ak, input logic [7:0] di,
                                input logic er, input logic ew, input logic [1:0] ep,
                                input logic [7:0] ed, input logic eb, input logic erv,
                                input logic [7:0] erd, input logic ef);
        vec_t v;
        v.c_req = cr; v.c_wr = cw; v.c_port = cp; v.c_wdata = wd; v.ack = ak; v.din = di;
        v.exp = {er, ew, ep, ed, eb, erv, erd, ef};
        return v;
    endfunction

    // Bounded wait for a request, then check it and acknowledge it for one cycle.
    task automatic serve(input string name, input logic ew, input logic [1:0] ep,
                         input logic [7:0] ed, input logic [7:0] di);
        int n = 0;
        while (!bus.vdp_io_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req"}, 32'(bus.vdp_io_req), 32'(1));
        if (ew) check(name, 32'({bus.vdp_io_wr, bus.vdp_port, bus.vdp_data_out}), 32'({ew, ep, ed}));
        else    check(name, 32'({bus.vdp_io_wr, bus.vdp_port}), 32'({ew, ep}));
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, di);
        tick();
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
    endtask

    // One cycle of random stimulus compared against the ordered-transaction model.
    task automatic step(input bit allow_cpu);
        op_t        front, op;
        logic       ack, ack_wr, nb, nrv, creq, cwr;
        logic [7:0] din, cdata;
        logic [1:0] cport;

        check("rnd_full", 32'(bus.q_full), 32'(model_cnt == int'(DEPTH)));
        check("rnd_busy", 32'(bus.cpu_busy), 32'(model_busy));
        check("rnd_rdv", 32'(bus.cpu_rd_valid), 32'(exp_rdv));
        if (exp_rdv) check("rnd_rdata", 32'(bus.cpu_rdata), 32'(pend_rdata));
        if (prev_ack) check("rnd_req_gap", 32'(bus.vdp_io_req), 32'(0));
        if (bus.vdp_io_req) begin
            check("rnd_req_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                front = exp_q[0];
                check("rnd_issue",
                      32'({bus.vdp_io_wr, bus.vdp_port, bus.vdp_io_wr ? bus.vdp_data_out : 8'h00}),
                      32'(front));
            end
        end

        din    = 8'($urandom);
        ack    = bus.vdp_io_req && !prev_ack && (exp_q.size() != 0) &&
                 ($urandom_range(0, 99) < (allow_cpu ? 40 : 100));
        ack_wr = 1'b0;
        nb     = model_busy;
        nrv    = 1'b0;
        if (ack) begin
            op = exp_q.pop_front();
            if (op.wr) begin
                model_cnt--;
                ack_wr = 1'b1;
            end else begin
                pend_rdata = din;
                nrv        = 1'b1;
                nb         = 1'b0;
            end
        end

        creq  = allow_cpu && ($urandom_range(0, 1) == 1);
        cwr   = ($urandom_range(0, 99) < 70);
        cport = 2'($urandom);
        cdata = 8'($urandom);
        if (creq) begin
            if (cwr) begin
                if (model_cnt < int'(DEPTH)) begin
                    exp_q.push_back({1'b1, cport, cdata});
                    model_cnt++;
                end else begin
                    drops_exp++;
                end
            end else if (model_busy) begin
                drops_exp++;
            end else begin
                exp_q.push_back({1'b0, cport, 8'h00});
                nb = 1'b1;
            end
        end

        drive(creq, cwr, cport, cdata, ack, din);
        tick();
        prev_ack   = ack;
        model_busy = nb;
        exp_rdv    = nrv;
        if (ack_wr) ack_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[19];
        int   n;

        vecs[0]  = mk(1,1,2'd1,8'h8F,0,8'h00, 1,1,2'd1,8'h8F,0,0,8'h00,0);
        vecs[1]  = mk(0,0,2'd0,8'h00,0,8'h00, 1,1,2'd1,8'h8F,0,0,8'h00,0);
        vecs[2]  = mk(0,0,2'd0,8'h00,0,8'h00, 1,1,2'd1,8'h8F,0,0,8'h00,0);
        vecs[3]  = mk(0,0,2'd0,8'h00,1,8'h00, 0,1,2'd1,8'h8F,0,0,8'h00,0);
        vecs[4]  = mk(0,0,2'd0,8'h00,0,8'h00, 0,1,2'd1,8'h8F,0,0,8'h00,0);
        vecs[5]  = mk(1,1,2'd0,8'h11,0,8'h00, 1,1,2'd0,8'h11,0,0,8'h00,0);
        vecs[6]  = mk(1,1,2'd1,8'h22,0,8'h00, 1,1,2'd0,8'h11,0,0,8'h00,0);
        vecs[7]  = mk(1,1,2'd3,8'h33,0,8'h00, 1,1,2'd0,8'h11,0,0,8'h00,0);
        vecs[8]  = mk(1,0,2'd2,8'h00,0,8'h00, 1,1,2'd0,8'h11,1,0,8'h00,0);
        vecs[9]  = mk(0,0,2'd0,8'h00,1,8'h00, 0,1,2'd0,8'h11,1,0,8'h00,0);
        vecs[10] = mk(1,0,2'd1,8'h00,0,8'h00, 1,1,2'd1,8'h22,1,0,8'h00,0);
        vecs[11] = mk(0,0,2'd0,8'h00,1,8'h00, 0,1,2'd1,8'h22,1,0,8'h00,0);
        vecs[12] = mk(0,0,2'd0,8'h00,0,8'h00, 1,1,2'd3,8'h33,1,0,8'h00,0);
        vecs[13] = mk(0,0,2'd0,8'h00,1,8'h00, 0,1,2'd3,8'h33,1,0,8'h00,0);
        vecs[14] = mk(0,0,2'd0,8'h00,0,8'h00, 1,0,2'd2,8'h33,1,0,8'h00,0);
        vecs[15] = mk(0,0,2'd0,8'h00,1,8'h5A, 0,0,2'd2,8'h33,0,1,8'h5A,0);
        vecs[16] = mk(0,0,2'd0,8'h00,0,8'h00, 0,0,2'd2,8'h33,0,0,8'h5A,0);
        vecs[17] = mk(1,1,2'd2,8'h44,0,8'h00, 1,1,2'd2,8'h44,0,0,8'h5A,0);
        vecs[18] = mk(0,0,2'd0,8'h00,1,8'h00, 0,1,2'd2,8'h44,0,0,8'h5A,0);

        reset = 1'b1;
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        tick();
        tick();
        check("reset_state", 32'(sample()), 32'(0));
        reset = 1'b0;

        // Single write with delayed ack, then three writes followed by a read.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].c_req, vecs[i].c_wr, vecs[i].c_port, vecs[i].c_wdata,
                  vecs[i].ack, vecs[i].din);
            tick();
            check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
        end
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        tick();
        drops_exp = 1;

        // Fill to DEPTH, overflow once, then push and pop together on a full queue.
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 2'(i % 4), 8'hA0 + 8'(i), 0, 8'h00);
            tick();
            if (i == 6) check("fill_not_full", 32'(bus.q_full), 32'(0));
            if (i == 7) check("fill_full", 32'(bus.q_full), 32'(1));
        end
        drops_exp++;
        check("overflow_still_full", 32'(bus.q_full), 32'(1));
        check("overflow_head", 32'({bus.vdp_io_req, bus.vdp_port, bus.vdp_data_out}),
              32'({1'b1, 2'd0, 8'hA0}));
`ifdef VDP_IO_QUEUE_DROP_STATS_EN
        check("drop_count_fill", 32'(drop_count), 32'(drops_exp));
        check("drop_flag_fill", 32'(drop_flag), 32'(1));
`endif
        drive(1, 1, 2'd1, 8'hA9, 1, 8'h00);
        tick();
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        check("push_pop_full", 32'(bus.q_full), 32'(1));
        for (int i = 1; i < 8; i++) begin
            serve($sformatf("drain%0d", i), 1'b1, 2'(i % 4), 8'hA0 + 8'(i), 8'h00);
            if (i == 1) check("drain_not_full", 32'(bus.q_full), 32'(0));
        end
        serve("drain_pushed", 1'b1, 2'd1, 8'hA9, 8'h00);

        // A write arriving behind a pending read must wait for the read to complete.
        drive(1, 0, 2'd1, 8'h00, 0, 8'h00);
        tick();
        check("rd_busy_set", 32'(bus.cpu_busy), 32'(1));
        drive(1, 1, 2'd0, 8'h11, 0, 8'h00);
        tick();
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        serve("rd_first", 1'b0, 2'd1, 8'h00, 8'hC3);
        check("rd_done", 32'({bus.cpu_rd_valid, bus.cpu_rdata, bus.cpu_busy, bus.vdp_io_req}),
              32'({1'b1, 8'hC3, 1'b0, 1'b0}));
        tick();
        check("wr_after_rd", 32'({bus.cpu_rd_valid, bus.vdp_io_req, bus.vdp_io_wr, bus.vdp_port,
                                 bus.vdp_data_out}),
              32'({1'b0, 1'b1, 1'b1, 2'd0, 8'h11}));
        serve("wr_after_rd_ack", 1'b1, 2'd0, 8'h11, 8'h00);

        // Reset in the middle of an outstanding write, with a stray ack right after.
        drive(1, 1, 2'd2, 8'h77, 0, 8'h00);
        tick();
        drive(1, 1, 2'd3, 8'h78, 0, 8'h00);
        tick();
        check("pre_reset_req", 32'(bus.vdp_io_req), 32'(1));
        reset = 1'b1;
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        tick();
        check("mid_reset_outs", 32'(sample()), 32'(0));
        reset = 1'b0;
        drive(0, 0, 2'd0, 8'h00, 1, 8'hEE);
        tick();
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        check("stray_ack_outs", 32'(sample()), 32'(0));
        tick();
        tick();
        check("queue_empty_after_reset", 32'(sample()), 32'(0));
`ifdef VDP_IO_QUEUE_DROP_STATS_EN
        check("drop_count_reset", 32'({drop_flag, drop_count}), 32'(0));
`endif
        drive(1, 1, 2'd1, 8'h5E, 0, 8'h00);
        tick();
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00);
        check("post_reset_write", 32'({bus.vdp_io_req, bus.vdp_port, bus.vdp_data_out}),
              32'({1'b1, 2'd1, 8'h5E}));
        serve("post_reset_ack", 1'b1, 2'd1, 8'h5E, 8'h00);

        // Random traffic against the in-order transaction model.
        model_cnt  = 0;
        model_busy = 1'b0;
        exp_rdv    = 1'b0;
        pend_rdata = 8'h00;
        prev_ack   = 1'b1;
        drops_exp  = 0;
        for (int c = 0; c < 3000; c++) begin
            step(1'b1);
        end
        n = 0;
        while ((exp_q.size() != 0 || exp_rdv) && n < 400) begin
            step(1'b0);
            n++;
        end
        check("rnd_drained", 32'(exp_q.size()), 32'(0));
`ifdef VDP_IO_QUEUE_DROP_STATS_EN
        check("rnd_drop_count", 32'(drop_count), 32'(drops_exp > 255 ? 255 : drops_exp));
        check("rnd_drop_flag", 32'(drop_flag), 32'(drops_exp != 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vdp_io_queue.md
VDP_IO_QUEUE -- requirements
Module: vdp_io_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, write-queue entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  pixel-domain clock (clk_w); one clock only.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_req  input  1  single-cycle CPU port access strobe from the CPU I/O block.
REQ-005 SHALL have port cpu_wr  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 SHALL have port cpu_port  input  2  VDP port index 0..3.
REQ-007 SHALL have port cpu_wdata  input  8  write data.
REQ-008 SHALL have port cpu_rdata  output  8  read data; valid with cpu_rd_valid.
REQ-009 SHALL have port cpu_rd_valid  output  1  one-cycle pulse when a read completes.
REQ-010 SHALL have port cpu_busy  output  1  high while a read is pending.
REQ-011 SHALL have port q_full  output  1  write queue full.
REQ-012 SHALL have port vdp_io_req  output  1  request to the VDP core; held until acknowledged.
REQ-013 SHALL have port vdp_io_wr  output  1  direction of the current request.
REQ-014 SHALL have port vdp_port  output  2  port index of the current request.
REQ-015 SHALL have port vdp_data_out  output  8  write data to the VDP (DBI).
REQ-016 SHALL have port vdp_data_in  input  8  read data from the VDP (DBO); valid in the ack cycle.
REQ-017 SHALL have port vdp_ack  input  1  VDP acknowledge; one-cycle pulse.

Function
REQ-018 Writes SHALL enter a FIFO of entries {port, data}; pushes occur on cpu_req & cpu_wr & ~q_full.
REQ-019 A write to a full queue SHALL be dropped; a simultaneous pop and push in the same cycle on a full queue SHALL accept the push.
REQ-020 The FSM SHALL have states IDLE, WR_ISSUE, RD_WAIT_DRAIN, RD_ISSUE.
REQ-021 IDLE -> WR_ISSUE when the queue is non-empty; vdp_io_req SHALL rise the cycle after the first push into an empty queue.
REQ-022 In WR_ISSUE, req/wr/port/data SHALL be held stable until vdp_ack; on ack, pop and return to IDLE with req low for at least one cycle.
REQ-023 A read (cpu_req & ~cpu_wr & ~cpu_busy) SHALL latch the port, set cpu_busy the next cycle, and enter RD_WAIT_DRAIN.
REQ-024 RD_WAIT_DRAIN -> RD_ISSUE once the queue is empty and no write is outstanding; reads never overtake earlier writes.
REQ-025 Writes arriving while a read is pending SHALL be queued and issued only after the read completes.
REQ-026 In RD_ISSUE, on vdp_ack, vdp_data_in SHALL be registered into cpu_rdata, cpu_rd_valid SHALL pulse the next cycle, cpu_busy SHALL clear that cycle, and the FSM SHALL return to IDLE.
REQ-027 A read request while cpu_busy is high SHALL be ignored.
REQ-028 Pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-029 Reset SHALL empty the queue, force IDLE, and drive vdp_io_req, cpu_rd_valid, cpu_busy and q_full to 0, and cpu_rdata, vdp_port and vdp_data_out to 0.
REQ-030 Reset during an outstanding request SHALL abandon it; a vdp_ack in the first cycle after reset SHALL be ignored.

Configuration
REQ-031 With VDP_IO_QUEUE_DROP_STATS_EN defined, the block SHALL add outputs drop_flag (1 bit, sticky, set on any dropped write or ignored read) and drop_count (8 bits, saturating at 255); both SHALL be cleared only by reset.
REQ-032 Without the macro, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-033 Package vdp_io_pkg SHALL hold the io_entry_t typedef {port[1:0], data[7:0]}, the FSM state enum, and the DEPTH default constant.
REQ-034 Storage SHALL be the sub-module vdp_io_fifo (synchronous FIFO with push, pop, full, empty and count).

Verification
REQ-035 Single write port 1 = 0x8F with ack 3 cycles later -> req rises next cycle, is held for 3 cycles with vdp_port=1 and data 0x8F, then drops.
REQ-036 9 back-to-back writes with DEPTH=8 and no ack -> q_full high after 8; the 9th write is dropped; drop_count=1 when the macro is defined.
REQ-037 3 queued writes, then read port 2 with vdp_data_in=0x5A -> all 3 writes are acked before the read req; cpu_rdata=0x5A with a one-cycle cpu_rd_valid; cpu_busy low afterwards.
REQ-038 Read pending, then a write of 0x11 -> the write is issued strictly after cpu_rd_valid.
REQ-039 Reset asserted mid-WR_ISSUE -> all outputs return to 0 next cycle; a stray ack is ignored; the queue is empty.
REQ-040 Push and pop in the same cycle on a full queue -> count stays at DEPTH; the pushed entry is issued in FIFO order.
